// File: rtl/hv_rac_pkg.sv
// hv_rac_pkg: shared types for the register-access controller.
//   rac_state_e : controller FSM states
//   rac_src_e   : which requester owns the current transaction
package hv_rac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        WR,
        RESP,
        HOLD
    } rac_state_e;

    typedef enum logic {
        SRC_OWT,
        SRC_SCAN
    } rac_src_e;

endpackage

// File: rtl/crc16to8_parallel.sv
// crc16to8_parallel: combinational CRC-8 (poly x^8+x^2+x+1, init 0,
// MSB first) over a 16-bit word.
//   i_data : 16-bit message
//   o_crc  : 8-bit remainder
module crc16to8_parallel (
    input  logic [15:0] i_data,
    output logic [7:0]  o_crc
);

    always_comb begin
        o_crc = 8'h00;
        for (int i = 15; i >= 0; i--) begin
            if (o_crc[7] ^ i_data[i]) begin
                o_crc = {o_crc[6:0], 1'b0} ^ 8'h07;
            end else begin
                o_crc = {o_crc[6:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/hv_param.svh
// Register-bank geometry used across the HV top.
`ifndef HV_PARAM_SVH
`define HV_PARAM_SVH
`define HV_REG_AW    7
`define HV_REG_DW    8
`define HV_REG_CRC_W 8
`endif

// File: rtl/hv_reg_access_ctrl.sv
// hv_reg_access_ctrl: responder side of the HV register-access handshake.
// Arbitrates the OWT host port (read/write) against the watchdog scan port
// (read-only), drives the register bank, and returns data + CRC8 of
// {1'b1, addr, data}. OWT writes are committed only when their CRC matches.
//   i_clk/i_rst_n          : clock, async active-low reset
//   i_wdg_scan_rac_*       : scan request/address, o_rac_wdg_scan_* ack/data/crc
//   i_scan_crc_inj         : flips bit0 of the returned scan CRC (BIST)
//   i_owt_rac_*            : OWT request, wr flag, address, wdata, wcrc
//   o_rac_owt_*            : OWT ack, rdata, rcrc, crc_err
//   o_reg_* / i_reg_rdata  : register bank bus
`include "hv_param.svh"

module hv_reg_access_ctrl
    import hv_rac_pkg::*;
#(
    parameter int REG_AW    = `HV_REG_AW,
    parameter int REG_DW    = `HV_REG_DW,
    parameter int REG_CRC_W = `HV_REG_CRC_W,
    parameter int RD_LAT    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_wdg_scan_rac_rd_req,
    input  logic [REG_AW-1:0]    i_wdg_scan_rac_addr,
    output logic                 o_rac_wdg_scan_ack,
    output logic [REG_DW-1:0]    o_rac_wdg_scan_data,
    output logic [REG_CRC_W-1:0] o_rac_wdg_scan_crc,
    input  logic                 i_scan_crc_inj,
    input  logic                 i_owt_rac_req,
    input  logic                 i_owt_rac_wr,
    input  logic [REG_AW-1:0]    i_owt_rac_addr,
    input  logic [REG_DW-1:0]    i_owt_rac_wdata,
    input  logic [REG_CRC_W-1:0] i_owt_rac_wcrc,
    output logic                 o_rac_owt_ack,
    output logic [REG_DW-1:0]    o_rac_owt_rdata,
    output logic [REG_CRC_W-1:0] o_rac_owt_rcrc,
    output logic                 o_rac_owt_crc_err,
    output logic                 o_reg_rd_en,
    output logic                 o_reg_wr_en,
    output logic [REG_AW-1:0]    o_reg_addr,
    output logic [REG_DW-1:0]    o_reg_wdata,
    input  logic [REG_DW-1:0]    i_reg_rdata
);

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    rac_state_e             r_state;
    rac_state_e             w_state_nxt;
    rac_src_e               r_src;
    logic                   r_wr;
    logic [REG_AW-1:0]      r_addr;
    logic [REG_DW-1:0]      r_wdata;
    logic [REG_CRC_W-1:0]   r_wcrc;
    logic                   r_crc_bad;
    logic [1:0]             r_lat_cnt;
    logic                   r_scan_prio;
    logic [REG_DW-1:0]      r_scan_data;
    logic [REG_CRC_W-1:0]   r_scan_crc;
    logic [REG_DW-1:0]      r_owt_rdata;
    logic [REG_CRC_W-1:0]   r_owt_rcrc;

    logic                   w_gnt_owt;
    logic                   w_gnt_scan;
    logic                   w_rd_en;
    logic                   w_wr_en;
    logic                   w_lat_done;
    logic                   w_crc_ok;
    logic [15:0]            w_crc_in;
    logic [REG_CRC_W-1:0]   w_crc;

    // One shared CRC: the WR state checks the write payload, every other
    // state (in practice the last WAIT cycle) covers the bank read data.
    assign w_crc_in = {1'b1, r_addr, (r_state == WR) ? r_wdata : i_reg_rdata};

    crc16to8_parallel u_crc (
        .i_data (w_crc_in),
        .o_crc  (w_crc)
    );

    assign w_crc_ok   = (w_crc == r_wcrc);
    assign w_lat_done = (r_lat_cnt == LAT_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_owt   = 1'b0;
        w_gnt_scan  = 1'b0;
        w_rd_en     = 1'b0;
        w_wr_en     = 1'b0;
        case (r_state)
            IDLE: begin
                // OWT wins unless a scan request was starved by the previous
                // OWT transaction.
                if (i_owt_rac_req && !(r_scan_prio && i_wdg_scan_rac_rd_req)) begin
                    w_gnt_owt   = 1'b1;
                    w_state_nxt = i_owt_rac_wr ? WR : RD;
                end else if (i_wdg_scan_rac_rd_req) begin
                    w_gnt_scan  = 1'b1;
                    w_state_nxt = RD;
                end
            end
            RD: begin
                w_rd_en     = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (w_lat_done) begin
                    w_state_nxt = RESP;
                end
            end
            WR: begin
                w_wr_en     = w_crc_ok;
                w_state_nxt = RESP;
            end
            RESP:    w_state_nxt = HOLD;
            HOLD:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_src       <= SRC_OWT;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wcrc      <= '0;
            r_crc_bad   <= 1'b0;
            r_lat_cnt   <= '0;
            r_scan_prio <= 1'b0;
            r_scan_data <= '0;
            r_scan_crc  <= '0;
            r_owt_rdata <= '0;
            r_owt_rcrc  <= '0;
        end else begin
            if (w_gnt_owt) begin
                r_src   <= SRC_OWT;
                r_wr    <= i_owt_rac_wr;
                r_addr  <= i_owt_rac_addr;
                r_wdata <= i_owt_rac_wdata;
                r_wcrc  <= i_owt_rac_wcrc;
            end else if (w_gnt_scan) begin
                r_src   <= SRC_SCAN;
                r_wr    <= 1'b0;
                r_addr  <= i_wdg_scan_rac_addr;
            end

            // Starvation flag: armed by a scan request seen during an OWT
            // transaction, dropped once scan is granted or gives up.
            if (r_state == IDLE) begin
                if (w_gnt_scan || !i_wdg_scan_rac_rd_req) begin
                    r_scan_prio <= 1'b0;
                end
            end else if (r_src == SRC_OWT && i_wdg_scan_rac_rd_req) begin
                r_scan_prio <= 1'b1;
            end

            if (r_state == RD) begin
                r_lat_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_lat_cnt <= r_lat_cnt + 2'd1;
            end

            if (r_state == WR) begin
                r_crc_bad <= !w_crc_ok;
            end

            // Read data is captured straight into the port registers, so
            // it appears together with the ack and holds until the next one.
            if (r_state == WAIT && w_lat_done) begin
                if (r_src == SRC_OWT) begin
                    r_owt_rdata <= i_reg_rdata;
                    r_owt_rcrc  <= w_crc;
                end else begin
                    r_scan_data <= i_reg_rdata;
                    r_scan_crc  <= w_crc ^ {{(REG_CRC_W-1){1'b0}}, i_scan_crc_inj};
                end
            end
        end
    end

    assign o_rac_owt_ack       = (r_state == RESP) && (r_src == SRC_OWT);
    assign o_rac_wdg_scan_ack  = (r_state == RESP) && (r_src == SRC_SCAN);
    assign o_rac_owt_crc_err   = o_rac_owt_ack && r_wr && r_crc_bad;
    assign o_rac_wdg_scan_data = r_scan_data;
    assign o_rac_wdg_scan_crc  = r_scan_crc;
    assign o_rac_owt_rdata     = r_owt_rdata;
    assign o_rac_owt_rcrc      = r_owt_rcrc;
    assign o_reg_rd_en         = w_rd_en;
    assign o_reg_wr_en         = w_wr_en;
    assign o_reg_addr          = (w_rd_en || w_wr_en) ? r_addr : '0;
    assign o_reg_wdata         = w_wr_en ? r_wdata : '0;

endmodule

// File: tb/tb_hv_reg_access_ctrl.sv
// tb_hv_reg_access_ctrl: scoreboard bench for hv_reg_access_ctrl.
// u_dut uses RD_LAT=1 with a writable bank model; u_dut3 uses RD_LAT=3 on
// the scan port only and exercises reset during WAIT.
module tb_hv_reg_access_ctrl;

    typedef struct {
        logic [7:0] data;
        logic [7:0] crc;
        logic       err;
        logic       is_rd;
        int         cyc;
    } exp_t;

    logic gclk = 1'b0;
    logic rst_n = 1'b0;
    logic rst3_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 gclk = ~gclk;
    always @(posedge gclk) cyc <= cyc + 1;

    // ---------------- DUT (RD_LAT = 1) signals
    logic       scan_req = 0, scan_inj = 0, scan_ack;
    logic [6:0] scan_addr = 0;
    logic [7:0] scan_data, scan_crc;
    logic       owt_req = 0, owt_wr = 0, owt_ack, owt_crc_err;
    logic [6:0] owt_addr = 0;
    logic [7:0] owt_wdata = 0, owt_wcrc = 0, owt_rdata, owt_rcrc;
    logic       reg_rd_en, reg_wr_en;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata, reg_rdata;

    // ---------------- DUT (RD_LAT = 3) signals
    logic       scan3_req = 0, scan3_ack;
    logic [6:0] scan3_addr = 0;
    logic [7:0] scan3_data, scan3_crc;
    logic       owt3_ack, owt3_crc_err;
    logic [7:0] owt3_rdata, owt3_rcrc;
    logic       rd3_en, wr3_en;
    logic [6:0] addr3;
    logic [7:0] wdata3, rdata3;
    logic       zero1 = 1'b0;
    logic [6:0] zero7 = 7'h00;
    logic [7:0] zero8 = 8'h00;

    hv_reg_access_ctrl #(.RD_LAT(1)) u_dut (
        .i_clk(gclk), .i_rst_n(rst_n),
        .i_wdg_scan_rac_rd_req(scan_req), .i_wdg_scan_rac_addr(scan_addr),
        .o_rac_wdg_scan_ack(scan_ack), .o_rac_wdg_scan_data(scan_data),
        .o_rac_wdg_scan_crc(scan_crc), .i_scan_crc_inj(scan_inj),
        .i_owt_rac_req(owt_req), .i_owt_rac_wr(owt_wr), .i_owt_rac_addr(owt_addr),
        .i_owt_rac_wdata(owt_wdata), .i_owt_rac_wcrc(owt_wcrc),
        .o_rac_owt_ack(owt_ack), .o_rac_owt_rdata(owt_rdata), .o_rac_owt_rcrc(owt_rcrc),
        .o_rac_owt_crc_err(owt_crc_err),
        .o_reg_rd_en(reg_rd_en), .o_reg_wr_en(reg_wr_en), .o_reg_addr(reg_addr),
        .o_reg_wdata(reg_wdata), .i_reg_rdata(reg_rdata)
    );

    hv_reg_access_ctrl #(.RD_LAT(3)) u_dut3 (
        .i_clk(gclk), .i_rst_n(rst3_n),
        .i_wdg_scan_rac_rd_req(scan3_req), .i_wdg_scan_rac_addr(scan3_addr),
        .o_rac_wdg_scan_ack(scan3_ack), .o_rac_wdg_scan_data(scan3_data),
        .o_rac_wdg_scan_crc(scan3_crc), .i_scan_crc_inj(zero1),
        .i_owt_rac_req(zero1), .i_owt_rac_wr(zero1), .i_owt_rac_addr(zero7),
        .i_owt_rac_wdata(zero8), .i_owt_rac_wcrc(zero8),
        .o_rac_owt_ack(owt3_ack), .o_rac_owt_rdata(owt3_rdata), .o_rac_owt_rcrc(owt3_rcrc),
        .o_rac_owt_crc_err(owt3_crc_err),
        .o_reg_rd_en(rd3_en), .o_reg_wr_en(wr3_en), .o_reg_addr(addr3),
        .o_reg_wdata(wdata3), .i_reg_rdata(rdata3)
    );

    // ---------------- reference models
    function automatic logic [7:0] init_val(input logic [6:0] a);
        return (a == 7'h5B) ? 8'hA5 : ({a, 1'b0} ^ 8'h3C);
    endfunction

    // Long division of d * x^8 by x^8+x^2+x+1.
    function automatic logic [7:0] crc_ref(input logic [15:0] d);
        logic [23:0] r;
        r = {d, 8'h00};
        for (int i = 23; i >= 8; i--) begin
            if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
        end
        return r[7:0];
    endfunction

    logic [7:0] exp_mem [128];
    logic [7:0] bank [128];
    logic [7:0] rpipe;
    logic [2:0][7:0] p3;

    // Bank with RD_LAT=1: data valid only in the cycle after rd_en.
    always @(posedge gclk) begin
        if (!rst_n) begin
            for (int i = 0; i < 128; i++) bank[i] <= init_val(7'(i));
            rpipe <= 8'h00;
        end else begin
            if (reg_wr_en) bank[reg_addr] <= reg_wdata;
            rpipe <= reg_rd_en ? bank[reg_addr] : 8'h00;
        end
    end
    assign reg_rdata = rpipe;

    // Read-only bank with RD_LAT=3.
    always @(posedge gclk) p3 <= {p3[1:0], rd3_en ? init_val(addr3) : 8'h00};
    assign rdata3 = p3[2];

    // ---------------- checking
    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    exp_t q_scan[$], q_owt[$], q_scan3[$];
    byte  ack_log[$];
    int   rd_cnt = 0, wr_cnt = 0, last_rd_cyc = 0, last_wr_cyc = 0, ack3_cnt = 0, last_rd3_cyc = 0;
    logic [6:0] last_rd_addr = 0, last_wr_addr = 0;
    logic [7:0] last_wr_data = 0;

    always @(negedge gclk) begin
        exp_t e;
        if (reg_rd_en) begin rd_cnt++; last_rd_cyc = cyc; last_rd_addr = reg_addr; end
        if (reg_wr_en) begin wr_cnt++; last_wr_cyc = cyc; last_wr_addr = reg_addr; last_wr_data = reg_wdata; end
        if (rd3_en) last_rd3_cyc = cyc;
        if (scan_ack) begin
            ack_log.push_back("S");
            if (q_scan.size() == 0) chk("scan_unexpected_ack", 1, 0);
            else begin
                e = q_scan.pop_front();
                chk("scan_data", scan_data, e.data);
                chk("scan_crc", scan_crc, e.crc);
                if (e.cyc >= 0) chk("scan_ack_cyc", cyc, e.cyc);
            end
        end
        if (owt_ack) begin
            ack_log.push_back("O");
            if (q_owt.size() == 0) chk("owt_unexpected_ack", 1, 0);
            else begin
                e = q_owt.pop_front();
                chk("owt_crc_err", owt_crc_err, e.err);
                if (e.is_rd) begin
                    chk("owt_rdata", owt_rdata, e.data);
                    chk("owt_rcrc", owt_rcrc, e.crc);
                end
                if (e.cyc >= 0) chk("owt_ack_cyc", cyc, e.cyc);
            end
        end
        if (scan3_ack) begin
            ack3_cnt++;
            if (q_scan3.size() == 0) chk("scan3_unexpected_ack", 1, 0);
            else begin
                e = q_scan3.pop_front();
                chk("scan3_data", scan3_data, e.data);
                chk("scan3_crc", scan3_crc, e.crc);
                chk("scan3_ack_cyc", cyc, e.cyc);
            end
        end
    end

    // ---------------- requester models
    task automatic scan_rd(input logic [6:0] a, input logic inj, input int hold,
                           input bit timed, output logic [7:0] got_crc);
        exp_t e;
        int   n;
        int   k;
        @(posedge gclk); #1;
        scan_req = 1; scan_addr = a; scan_inj = inj; n = cyc;
        e.data = exp_mem[a];
        e.crc = crc_ref({1'b1, a, exp_mem[a]}) ^ {7'b0, inj};
        e.err = 0; e.is_rd = 1; e.cyc = timed ? n + 3 : -1;
        q_scan.push_back(e);
        for (k = 0; k < 40; k++) begin
            @(negedge gclk);
            if (scan_ack) break;
        end
        chk("scan_ack_seen", scan_ack, 1);
        got_crc = scan_crc;
        if (timed) begin
            chk("scan_rd_en_cyc", last_rd_cyc, n + 1);
            chk("scan_rd_addr", last_rd_addr, a);
        end
        repeat (hold) @(posedge gclk);
        @(posedge gclk); #1;
        scan_req = 0; scan_inj = 0;
    endtask

    task automatic owt_xfer(input logic wr, input logic [6:0] a, input logic [7:0] wd,
                            input logic bad, input bit timed);
        exp_t e;
        int   n;
        int   k;
        int   wr0;
        @(posedge gclk); #1;
        wr0 = wr_cnt;
        owt_req = 1; owt_wr = wr; owt_addr = a; owt_wdata = wd;
        owt_wcrc = crc_ref({1'b1, a, wd}) ^ {7'b0, bad};
        n = cyc;
        e.data = exp_mem[a];
        e.crc = crc_ref({1'b1, a, exp_mem[a]});
        e.err = wr & bad; e.is_rd = !wr;
        e.cyc = !timed ? -1 : (wr ? n + 2 : n + 3);
        q_owt.push_back(e);
        if (wr && !bad) exp_mem[a] = wd;
        for (k = 0; k < 40; k++) begin
            @(negedge gclk);
            if (owt_ack) break;
        end
        chk("owt_ack_seen", owt_ack, 1);
        if (wr && !bad && timed) begin
            chk("wr_en_cyc", last_wr_cyc, n + 1);
            chk("wr_addr", last_wr_addr, a);
            chk("wr_data", last_wr_data, wd);
        end
        if (wr && bad) chk("wr_rejected", wr_cnt, wr0);
        @(posedge gclk); #1;
        owt_req = 0;
    endtask

    // ---------------- stimulus
    initial begin
        logic [7:0] c;
        logic [6:0] a;
        byte        alt_exp [8];
        int         rd0;
        int         n;
        int         k;
        int         a3;
        exp_t       e;

        for (int i = 0; i < 128; i++) exp_mem[i] = init_val(7'(i));

        repeat (3) @(posedge gclk);
        @(negedge gclk);
        chk("rst_outs", {scan_ack, scan_data, scan_crc, owt_ack, owt_rdata, owt_rcrc,
                         owt_crc_err, reg_rd_en, reg_wr_en, reg_addr, reg_wdata}, 0);
        @(posedge gclk); #1;
        rst_n = 1; rst3_n = 1;
        repeat (2) @(posedge gclk);

        // Scan read with and without CRC injection.
        scan_rd(7'h5B, 1'b0, 0, 1, c);
        chk("scan_crc_flag", c != crc_ref({1'b1, 7'h5B, 8'hA5}), 0);
        scan_rd(7'h5B, 1'b1, 0, 1, c);
        chk("scan_inj_flag", c != crc_ref({1'b1, 7'h5B, 8'hA5}), 1);

        // OWT: rejected write, read back, good write, read back.
        owt_xfer(1, 7'h01, 8'h3C, 1, 1);
        owt_xfer(0, 7'h01, 8'h00, 0, 1);
        owt_xfer(1, 7'h01, 8'h3C, 0, 1);
        owt_xfer(0, 7'h01, 8'h00, 0, 1);

        // Simultaneous requests, OWT re-requesting: strict alternation.
        ack_log.delete();
        fork
            begin
                for (int i = 0; i < 4; i++) owt_xfer(0, 7'(8'h20 + i), 8'h00, 0, 0);
            end
            begin
                logic [7:0] cc;
                for (int i = 0; i < 4; i++) scan_rd(7'(8'h40 + i), 1'b0, 0, 0, cc);
            end
        join
        alt_exp = '{"O", "S", "O", "S", "O", "S", "O", "S"};
        chk("alt_len", ack_log.size(), 8);
        for (int i = 0; i < 8 && i < ack_log.size(); i++) chk("alt_order", ack_log[i], alt_exp[i]);

        // Back-to-back scan reads, requester holding req into HOLD.
        rd0 = rd_cnt;
        for (int i = 0; i < 17; i++) begin
            a = 7'h70 + 7'(i);
            scan_rd(a, 1'b0, 1, 1, c);
        end
        chk("b2b_rd_cnt", rd_cnt - rd0, 17);

        // RD_LAT=3 instance: normal read.
        @(posedge gclk); #1;
        scan3_req = 1; scan3_addr = 7'h2A; n = cyc;
        e.data = init_val(7'h2A); e.crc = crc_ref({1'b1, 7'h2A, init_val(7'h2A)});
        e.err = 0; e.is_rd = 1; e.cyc = n + 5;
        q_scan3.push_back(e);
        for (k = 0; k < 40; k++) begin @(negedge gclk); if (scan3_ack) break; end
        chk("scan3_ack_seen", scan3_ack, 1);
        chk("scan3_rd_en_cyc", last_rd3_cyc, n + 1);
        @(posedge gclk); #1; scan3_req = 0;
        repeat (2) @(posedge gclk);

        // RD_LAT=3 instance: reset while in WAIT.
        #1; scan3_req = 1; scan3_addr = 7'h11; a3 = ack3_cnt;
        repeat (3) @(posedge gclk); #1;
        rst3_n = 0; scan3_req = 0;
        @(negedge gclk);
        chk("rst3_outs", {scan3_ack, scan3_data, scan3_crc, owt3_ack, owt3_rdata, owt3_rcrc,
                          owt3_crc_err, rd3_en, wr3_en, addr3, wdata3}, 0);
        repeat (2) @(posedge gclk); #1;
        rst3_n = 1;
        repeat (8) @(posedge gclk);
        chk("rst3_no_ack", ack3_cnt, a3);

        #1; scan3_req = 1; scan3_addr = 7'h7F; n = cyc;
        e.data = init_val(7'h7F); e.crc = crc_ref({1'b1, 7'h7F, init_val(7'h7F)});
        e.err = 0; e.is_rd = 1; e.cyc = n + 5;
        q_scan3.push_back(e);
        for (k = 0; k < 40; k++) begin @(negedge gclk); if (scan3_ack) break; end
        chk("scan3_post_rst_ack", scan3_ack, 1);
        @(posedge gclk); #1; scan3_req = 0;

        repeat (5) @(posedge gclk);
        chk("q_scan_left", q_scan.size(), 0);
        chk("q_owt_left", q_owt.size(), 0);
        chk("q_scan3_left", q_scan3.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: act=time_limit exp=finish");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/hv_reg_access_ctrl.md
Name: hv_reg_access_ctrl

Overview:
Responder side of the register-access handshake in hv_top. It arbitrates two requesters: the OWT host port (read/write) and the watchdog scan port (read-only). It drives the HV register bank bus and returns an ack with data plus CRC8. The CRC8 is computed over {1'b1, addr, data}, which lets the scan initiator verify register integrity end to end. OWT writes carry a CRC8 that is checked before the write is committed.

Parameters:
REG_AW, 7, register address width
REG_DW, 8, register data width
REG_CRC_W, 8, CRC width (crc16to8 output)
RD_LAT, 1, register bank read latency in cycles after o_reg_rd_en (legal 1..3)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_wdg_scan_rac_rd_req  in  1  scan read request, level, held until ack
i_wdg_scan_rac_addr  in  REG_AW  scan address, stable while req high
o_rac_wdg_scan_ack  out  1  one-cycle ack to scan port
o_rac_wdg_scan_data  out  REG_DW  scan read data
o_rac_wdg_scan_crc  out  REG_CRC_W  CRC8 of {1'b1, addr, data}
i_scan_crc_inj  in  1  BIST fault injection: invert bit0 of scan CRC
i_owt_rac_req  in  1  OWT request, level, held until ack
i_owt_rac_wr  in  1  1 = write, 0 = read
i_owt_rac_addr  in  REG_AW  OWT address
i_owt_rac_wdata  in  REG_DW  OWT write data
i_owt_rac_wcrc  in  REG_CRC_W  CRC8 of {1'b1, addr, wdata}
o_rac_owt_ack  out  1  one-cycle ack to OWT port
o_rac_owt_rdata  out  REG_DW  OWT read data
o_rac_owt_rcrc  out  REG_CRC_W  CRC8 of {1'b1, addr, rdata}
o_rac_owt_crc_err  out  1  one-cycle pulse with ack: write rejected on CRC mismatch
o_reg_rd_en  out  1  register bank read strobe
o_reg_wr_en  out  1  register bank write strobe
o_reg_addr  out  REG_AW  register bank address
o_reg_wdata  out  REG_DW  register bank write data
i_reg_rdata  in  REG_DW  register bank read data

Behaviour:
- Reset: all outputs 0, FSM in IDLE, latched address/data/source cleared.
- FSM states:
  - IDLE: sample requests. OWT has fixed priority over scan. On grant, latch source, wr flag, address, and wdata/wcrc. Read -> RD; write -> WR.
  - RD: assert o_reg_rd_en and o_reg_addr = latched addr for exactly 1 cycle, then go to WAIT.
  - WAIT: count RD_LAT cycles, capture i_reg_rdata in the last cycle, then go to RESP.
  - WR: compute crc_ok = (CRC8{1'b1, addr, wdata} == latched wcrc). If crc_ok, assert o_reg_wr_en, o_reg_addr and o_reg_wdata for 1 cycle. If not, do not write. Then go to RESP.
  - RESP: pulse the ack of the granted port only. Data and CRC outputs update in the same cycle and hold until that port's next ack. Then go to HOLD.
  - HOLD: 1 cycle. Requests are ignored, because requesters drop req in the cycle after ack. Then go to IDLE.
- Read latency, with req high in IDLE at cycle N:
  - rd_en at N+1
  - ack at N+2+RD_LAT
  - next grant no earlier than N+4+RD_LAT
- Write latency: wr_en at N+1, ack at N+2.
- Scan CRC output: o_rac_wdg_scan_crc = crc ^ {7'b0, i_scan_crc_inj}, with i_scan_crc_inj sampled in the WAIT→RESP transition cycle.
- o_rac_owt_crc_err is high only in the OWT ack cycle of a rejected write.
- Simultaneous OWT and scan requests in IDLE: OWT granted. The scan request stays pending and is granted in the next IDLE.
- Scan starvation: a scan request that is pending during an OWT transaction wins the next IDLE even if OWT requests again. This is a one-shot alternation flag, cleared on scan grant.
- Request dropped after grant: the transaction completes and ack is still pulsed. Request dropped before grant: no action.
- An address outside the bank needs no special handling here; the bank returns 0.
- A single crc16to8 instance is shared. Its input is muxed: WR uses {1'b1, addr, wdata}; otherwise {1'b1, addr, rdata}.
- Reset asserted mid-transaction: immediate return to IDLE, no ack issued, strobes deasserted.

Decomposition:
- Package hv_rac_pkg: state enum (IDLE, RD, WAIT, WR, RESP, HOLD) and source enum (SRC_OWT, SRC_SCAN).
- REG_AW, REG_DW and REG_CRC_W come from hv_param.svh.
- Reuse existing crc16to8_parallel as the only sub-module instance. No new sub-module.

Test Plan:
- Scan read, addr 7'h5B, bank returns 8'hA5, RD_LAT=1:
  - rd_en at N+1, ack at N+3, data 8'hA5.
  - crc equals crc16to8({1'b1, 7'h5B, 8'hA5}) from the reference model.
- Same read with i_scan_crc_inj=1 -> crc bit0 inverted vs model; the wdg initiator model flags crc_err.
- OWT write, addr 7'h01, wdata 8'h3C:
  - Correct wcrc -> wr_en at N+1 with addr/wdata, ack at N+2, crc_err=0.
  - wcrc^8'h01 -> no wr_en, ack with crc_err=1.
- OWT and scan requests raised in the same cycle -> OWT acked first, scan acked next. With OWT re-requesting continuously, scan and OWT alternate grants.
- Requester holds req one cycle after ack -> no second grant during HOLD. Exactly one rd_en per request across 17 back-to-back scan addresses.
- RD_LAT=3 build -> ack at N+5. Reset asserted in WAIT -> no ack, all outputs 0, next request serviced normally.
